// File: rtl/mem_req_ctrl.sv
// Request controller in front of a single-port synchronous memory: one access at a time,
// read data returned on a valid/ready channel. Optional write-back verify: MEM_REQ_CTRL_WB_VERIFY_EN.
module mem_req_ctrl #(
   parameter int DW     = 8,
   parameter int AW     = 2,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d_i,
   input  logic [DW-1:0] mem_d_o,
   output logic          busy,
   output logic          wb_err,
   output logic [2:0]    o_dbg_state
);

   // Handshakes: a transfer happens on a posedge where valid & ready are both high.
   // The producer holds req_* stable until accepted; rsp_valid/rsp_rdata hold until rsp_ready.

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_RD_ISSUE  = 3'd2,
      ST_RD_WAIT   = 3'd3,
`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
      ST_VFY_ISSUE = 3'd5,
      ST_VFY_WAIT  = 3'd6,
`endif
      ST_RESP      = 3'd4
   } state_t;

   state_t        r_state;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_a;
   logic [DW-1:0] r_mem_d_i;
   logic          r_rsp_valid;
   logic [DW-1:0] r_rsp_rdata;
   logic [CW-1:0] r_cnt;
   logic          w_idle;

`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
   logic          r_wb_err;
`endif

   assign w_idle = (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mem_we    <= 1'b0;
         r_mem_a     <= '0;
         r_mem_d_i   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_cnt       <= '0;
`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
         r_wb_err    <= 1'b0;
`endif
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_mem_a <= req_addr;
                  if (req_we) begin
                     r_mem_we  <= 1'b1;
                     r_mem_d_i <= req_wdata;
                     r_state   <= ST_WRITE;
                  end else begin
                     r_state <= ST_RD_ISSUE;
                  end
               end
            end
            ST_WRITE: begin
`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
               r_state <= ST_VFY_ISSUE;
`else
               r_state <= ST_IDLE;
`endif
            end
            ST_RD_ISSUE: begin
               r_cnt   <= CW'(RD_LAT - 1);
               r_state <= ST_RD_WAIT;
            end
            // Capture only after RD_LAT full cycles so the memory's output has settled.
            ST_RD_WAIT: begin
               if (r_cnt == '0) begin
                  r_rsp_rdata <= mem_d_o;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
            ST_VFY_ISSUE: begin
               r_cnt   <= CW'(RD_LAT - 1);
               r_state <= ST_VFY_WAIT;
            end
            // mem_d_i still holds the written word, so it doubles as the compare reference.
            ST_VFY_WAIT: begin
               if (r_cnt == '0) begin
                  if (mem_d_o != r_mem_d_i) r_wb_err <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = w_idle;
   assign busy        = !w_idle;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign mem_we      = r_mem_we;
   assign mem_a       = r_mem_a;
   assign mem_d_i     = r_mem_d_i;
   assign o_dbg_state = r_state;

`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
   assign wb_err = r_wb_err;
`else
   assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: transaction-timeline model checked every cycle, plus directed
// literal checks and randomized request traffic.
module tb_mem_req_ctrl;

   localparam int DW     = 8;
   localparam int AW     = 2;
   localparam int RD_LAT = 1;
`ifdef MEM_REQ_CTRL_WB_VERIFY_EN
   localparam bit VFY = 1'b1;
`else
   localparam bit VFY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_d_i;
   logic [DW-1:0] mem_d_o = '0;
   logic          busy;
   logic          wb_err;
   logic [2:0]    dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   bit force_zero = 1'b0;
   int rsp_mode = 0;  // 0: hold rsp_ready low, 1: high, 2: random

   always #5 clk = ~clk;

   mem_req_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .mem_we(mem_we), .mem_a(mem_a), .mem_d_i(mem_d_i), .mem_d_o(mem_d_o),
      .busy(busy), .wb_err(wb_err), .o_dbg_state(dbg_state)
   );

   // Memory: registered read, optionally forced to return zero.
   logic [DW-1:0] tb_mem [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
   always @(posedge clk) begin
      if (mem_we) tb_mem[mem_a] <= mem_d_i;
      mem_d_o <= force_zero ? '0 : tb_mem[mem_a];
   end

   // Timeline model: each accepted request fixes the edge at which it completes.
   logic [DW-1:0] m_mem [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
   int            cyc = 0;
   int            m_done_at = 0;
   logic          m_ready = 1'b1;
   logic          m_is_rd = 1'b0;
   logic          m_vbad = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic          exp_we = 1'b0, exp_rv = 1'b0, exp_err = 1'b0;
   logic [AW-1:0] exp_a = '0;
   logic [DW-1:0] exp_d = '0, exp_rd = '0;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_ready = 1'b1; exp_we = 1'b0; exp_a = '0; exp_d = '0;
         exp_rv = 1'b0; exp_rd = '0; exp_err = 1'b0;
      end else begin
         exp_we = 1'b0;
         if (m_ready && req_valid) begin
            m_ready = 1'b0;
            exp_a   = req_addr;
            if (req_we) begin
               exp_we = 1'b1;
               exp_d  = req_wdata;
               m_mem[req_addr] = req_wdata;
               m_is_rd   = 1'b0;
               m_done_at = cyc + (VFY ? 2 + RD_LAT : 1);
               m_vbad    = force_zero && (req_wdata != '0);
            end else begin
               m_is_rd   = 1'b1;
               m_done_at = cyc + 1 + RD_LAT;
               m_rdata   = m_mem[req_addr];
            end
         end else if (!m_ready) begin
            if (exp_rv) begin
               if (rsp_ready) begin exp_rv = 1'b0; m_ready = 1'b1; end
            end else if (cyc == m_done_at) begin
               if (m_is_rd) begin
                  exp_rv = 1'b1; exp_rd = m_rdata;
               end else begin
                  m_ready = 1'b1;
                  if (VFY && m_vbad) exp_err = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s @%0t: timed out", nm, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", req_ready, m_ready);
         chk("busy", busy, !m_ready);
         chk("mem_we", mem_we, exp_we);
         chk("mem_a", mem_a, exp_a);
         chk("mem_d_i", mem_d_i, exp_d);
         chk("rsp_valid", rsp_valid, exp_rv);
         chk("rsp_rdata", rsp_rdata, exp_rd);
         chk("wb_err", wb_err, exp_err);
      end
   end

   initial forever begin
      @(negedge clk);
      #1;
      case (rsp_mode)
         0:       rsp_ready = 1'b0;
         1:       rsp_ready = 1'b1;
         default: rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
      int n = 0;
      bit t;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      forever begin
         t = req_ready;
         @(posedge clk);
         if (t) break;
         n++;
         if (n > 200) begin tmo("send"); break; end
         @(negedge clk);
      end
      @(negedge clk);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!req_ready) begin
         @(negedge clk);
         n++;
         if (n > 200) begin tmo("wait_idle"); break; end
      end
   endtask

   task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
      int n = 0;
      wait_idle();
      rsp_mode = 1;
      send(1'b0, a, '0, 1'b0);
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      if (rsp_valid) chk(nm, rsp_rdata, exp);
      else tmo(nm);
   endtask

   initial begin
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", req_ready, 1); chk("rst_busy", busy, 0);
      chk("rst_rv", rsp_valid, 0);    chk("rst_rd", rsp_rdata, 0);
      chk("rst_we", mem_we, 0);       chk("rst_a", mem_a, 0);
      chk("rst_d", mem_d_i, 0);       chk("rst_err", wb_err, 0);

      // Write 22 to addr 1: single-cycle pulse, no response.
      send(1'b1, 2'd1, 8'd22, 1'b0);
      chk("wr_we_k", mem_we, 1); chk("wr_a_k", mem_a, 1); chk("wr_d_k", mem_d_i, 22);
      chk("wr_ready_k", req_ready, 0);
      @(negedge clk);
      chk("wr_we_k1", mem_we, 0); chk("wr_rv_k1", rsp_valid, 0);
      chk("wr_ready_k1", req_ready, VFY ? 0 : 1);

      // Read addr 1 with response back-pressure.
      wait_idle();
      rsp_mode = 0;
      send(1'b0, 2'd1, '0, 1'b0);
      chk("rd_rv_k", rsp_valid, 0);
      @(negedge clk);
      chk("rd_rv_k1", rsp_valid, 0);
      @(negedge clk);
      chk("rd_rv_k2", rsp_valid, 1); chk("rd_data_k2", rsp_rdata, 22);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rd_hold_v", rsp_valid, 1); chk("rd_hold_d", rsp_rdata, 22);
      end
      rsp_mode = 1;
      @(negedge clk);
      chk("rd_hs_rv", rsp_valid, 0); chk("rd_hs_ready", req_ready, 1);

      // Back-to-back: write 33 then read addr 1 with valid held high.
      wait_idle();
      send(1'b1, 2'd1, 8'd33, 1'b1);
      read_check(2'd1, 8'd33, "b2b_read");

      // Reset in RD_WAIT drops the read.
      wait_idle();
      send(1'b0, 2'd1, '0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rdwait_rst_rv", rsp_valid, 0);
      end
      read_check(2'd1, 8'd33, "after_rst_read");

      // Two-cycle reset during a write; the write pulse still reaches the memory.
      wait_idle();
      send(1'b1, 2'd3, 8'd55, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("wrst_ready", req_ready, 1); chk("wrst_busy", busy, 0);
      chk("wrst_we", mem_we, 0);       chk("wrst_a", mem_a, 0);
      chk("wrst_d", mem_d_i, 0);       chk("wrst_rv", rsp_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      read_check(2'd3, 8'd55, "wrst_read");

      // Random traffic.
      rsp_mode = 2;
      for (int i = 0; i < 300; i++) begin
         bit keep;
         keep = ($urandom_range(0, 3) == 0);
         send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), keep);
         if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      req_valid = 1'b0;

      // Faulty memory: verify flags the write-back (verify builds only).
      wait_idle();
      rsp_mode = 1;
      force_zero = 1'b1;
      send(1'b1, 2'd0, 8'd44, 1'b0);
      @(negedge clk);
      chk("vfy_err_k1", wb_err, 0);
      @(negedge clk);
      chk("vfy_err_k2", wb_err, 0);
      @(negedge clk);
      chk("vfy_err_k3", wb_err, VFY ? 1 : 0);
      wait_idle();
      send(1'b1, 2'd2, 8'd0, 1'b0);
      repeat (5) @(negedge clk);
      chk("vfy_sticky", wb_err, VFY ? 1 : 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("vfy_rst_clr", wb_err, 0);
      force_zero = 1'b0;
      wait_idle();
      send(1'b1, 2'd1, 8'd77, 1'b0);
      repeat (5) @(negedge clk);
      chk("vfy_good_mem", wb_err, 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
